// File: rtl/cc_datasender.sv
// cc_datasender: transmit-side companion of the data-delay stage.
// Accepts one word at a time over a valid/ready handshake, holds it on the
// output bus for SETUP_CYCLES, fires a one-cycle send strobe, then holds it
// for HOLD_CYCLES more cycles before accepting the next word.
// Optional feature macro: CC_DATASENDER_PARITY_EN adds CC_DATASENDER_Parity_Out,
// the even parity of the accepted word, registered alongside the data.
module cc_datasender #(
   parameter int DATAWIDTH_BUS = 8,
   parameter int SETUP_CYCLES  = 2,
   parameter int HOLD_CYCLES   = 1
) (
   input  logic                     CC_DATASENDER_CLOCK_50,
   input  logic                     CC_DATASENDER_RESET_InHigh,
   input  logic [DATAWIDTH_BUS-1:0] CC_DATASENDER_Data_inBus,
   input  logic                     CC_DATASENDER_DataValid_In,
   output logic                     CC_DATASENDER_DataReady_Out,
   output logic [DATAWIDTH_BUS-1:0] CC_DATASENDER_Data_outBus,
   output logic                     CC_DATASENDER_SendDataSignal_Out,
   output logic                     CC_DATASENDER_Busy_Out
`ifdef CC_DATASENDER_PARITY_EN
   ,
   output logic                     CC_DATASENDER_Parity_Out
`endif
);

   // The counter must hold the larger of the two reload values.
   localparam int MAX_CYCLES = (SETUP_CYCLES > HOLD_CYCLES) ? SETUP_CYCLES : HOLD_CYCLES;
   localparam int CW         = (MAX_CYCLES > 0) ? $clog2(MAX_CYCLES + 1) : 1;

   localparam logic [CW-1:0] SETUP_LOAD = CW'(SETUP_CYCLES - 1);
   localparam logic [CW-1:0] HOLD_LOAD  = (HOLD_CYCLES > 0) ? CW'(HOLD_CYCLES - 1) : '0;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      STROBE = 2'd2,
      HOLD   = 2'd3
   } state_t;

   state_t                   state;
   state_t                   state_next;
   logic [CW-1:0]            cnt;
   logic [CW-1:0]            cnt_next;
   logic                     accept;
   logic [DATAWIDTH_BUS-1:0] data_q;
   logic                     strobe_q;

   // Ready is a pure Moore decode of IDLE, masked while reset is held.
   always_comb begin
      CC_DATASENDER_DataReady_Out = (state == IDLE) & ~CC_DATASENDER_RESET_InHigh;
      CC_DATASENDER_Busy_Out      = (state != IDLE);
      accept                      = CC_DATASENDER_DataValid_In & CC_DATASENDER_DataReady_Out;
   end

   // Next-state and counter logic; counter only loads or decrements toward 0.
   always_comb begin
      state_next = state;
      cnt_next   = cnt;
      case (state)
         IDLE: begin
            if (accept) begin
               state_next = SETUP;
               cnt_next   = SETUP_LOAD;
            end
         end
         SETUP: begin
            if (cnt == '0) begin
               state_next = STROBE;
            end else begin
               cnt_next = cnt - CW'(1);
            end
         end
         STROBE: begin
            if (HOLD_CYCLES == 0) begin
               state_next = IDLE;
            end else begin
               state_next = HOLD;
               cnt_next   = HOLD_LOAD;
            end
         end
         HOLD: begin
            if (cnt == '0) begin
               state_next = IDLE;
            end else begin
               cnt_next = cnt - CW'(1);
            end
         end
         default: begin
            state_next = IDLE;
            cnt_next   = '0;
         end
      endcase
   end

   // State register and counter; reset drops any word in flight.
   always_ff @(posedge CC_DATASENDER_CLOCK_50) begin
      if (CC_DATASENDER_RESET_InHigh) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         state <= state_next;
         cnt   <= cnt_next;
      end
   end

   // Strobe is registered so it is high exactly for the cycle spent in STROBE.
   always_ff @(posedge CC_DATASENDER_CLOCK_50) begin
      if (CC_DATASENDER_RESET_InHigh) begin
         strobe_q <= 1'b0;
      end else begin
         strobe_q <= (state_next == STROBE);
      end
   end

   // Output word captured only on acceptance and held until the next one.
   always_ff @(posedge CC_DATASENDER_CLOCK_50) begin
      if (CC_DATASENDER_RESET_InHigh) begin
         data_q <= '0;
      end else if (accept) begin
         data_q <= CC_DATASENDER_Data_inBus;
      end
   end

   assign CC_DATASENDER_Data_outBus        = data_q;
   assign CC_DATASENDER_SendDataSignal_Out = strobe_q;

`ifdef CC_DATASENDER_PARITY_EN
   logic parity_q;

   // Parity of the accepted word, captured on the same edge as the data.
   always_ff @(posedge CC_DATASENDER_CLOCK_50) begin
      if (CC_DATASENDER_RESET_InHigh) begin
         parity_q <= 1'b0;
      end else if (accept) begin
         parity_q <= ^CC_DATASENDER_Data_inBus;
      end
   end

   assign CC_DATASENDER_Parity_Out = parity_q;
`endif

endmodule

// File: tb/tb_cc_datasender.sv
// Directed self-checking bench for cc_datasender.
// dut uses the default timing (setup 2, hold 1); dut2 uses setup 1, hold 0.
// When CC_DATASENDER_PARITY_EN is defined the parity outputs are also checked.
module tb_cc_datasender;

   logic       clk = 1'b0;
   logic       reset;
   logic [7:0] data_in;
   logic       valid;
   logic       ready;
   logic [7:0] data_out;
   logic       strobe;
   logic       busy;

   logic [7:0] data_in2;
   logic       valid2;
   logic       ready2;
   logic [7:0] data_out2;
   logic       strobe2;
   logic       busy2;

`ifdef CC_DATASENDER_PARITY_EN
   logic       parity;
   logic       parity2;
`endif

   int total = 0;
   int bad   = 0;
   int strobe_count;

   always #5 clk = ~clk;

   cc_datasender #(.DATAWIDTH_BUS(8), .SETUP_CYCLES(2), .HOLD_CYCLES(1)) dut (
      .CC_DATASENDER_CLOCK_50           (clk),
      .CC_DATASENDER_RESET_InHigh       (reset),
      .CC_DATASENDER_Data_inBus         (data_in),
      .CC_DATASENDER_DataValid_In       (valid),
      .CC_DATASENDER_DataReady_Out      (ready),
      .CC_DATASENDER_Data_outBus        (data_out),
      .CC_DATASENDER_SendDataSignal_Out (strobe),
      .CC_DATASENDER_Busy_Out           (busy)
`ifdef CC_DATASENDER_PARITY_EN
      ,
      .CC_DATASENDER_Parity_Out         (parity)
`endif
   );

   cc_datasender #(.DATAWIDTH_BUS(8), .SETUP_CYCLES(1), .HOLD_CYCLES(0)) dut2 (
      .CC_DATASENDER_CLOCK_50           (clk),
      .CC_DATASENDER_RESET_InHigh       (reset),
      .CC_DATASENDER_Data_inBus         (data_in2),
      .CC_DATASENDER_DataValid_In       (valid2),
      .CC_DATASENDER_DataReady_Out      (ready2),
      .CC_DATASENDER_Data_outBus        (data_out2),
      .CC_DATASENDER_SendDataSignal_Out (strobe2),
      .CC_DATASENDER_Busy_Out           (busy2)
`ifdef CC_DATASENDER_PARITY_EN
      ,
      .CC_DATASENDER_Parity_Out         (parity2)
`endif
   );

   // Compare one observed value against its hand-computed expectation.
   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      total++;
      if (observed !== expected) begin
         bad++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
      end
   endtask

   // Drive the upstream handshake of the default-timing instance.
   task automatic applyStimulus(input logic v, input logic [7:0] d);
      valid   = v;
      data_in = d;
   endtask

   // Advance one clock edge and settle so outputs are sampled off the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset    = 1'b1;
      valid2   = 1'b0;
      data_in2 = 8'h00;
      applyStimulus(1'b1, 8'h5A);

      // Reset held 3 cycles with valid high: nothing moves
      for (int i = 0; i < 3; i++) begin
         tick();
         checkOutput("rst_ready", ready, 0);
         checkOutput("rst_data", data_out, 8'h00);
         checkOutput("rst_strobe", strobe, 0);
         checkOutput("rst_busy", busy, 0);
      end
`ifdef CC_DATASENDER_PARITY_EN
      checkOutput("rst_parity", parity, 0);
`endif
      reset = 1'b0;
      applyStimulus(1'b0, 8'h00);
      #1;
      checkOutput("rel_ready", ready, 1);

      // Single word 0xA5 accepted at edge 0
      applyStimulus(1'b1, 8'hA5);
      tick();
      applyStimulus(1'b0, 8'h00);
      checkOutput("sw_data_e0", data_out, 8'hA5);
      checkOutput("sw_busy_e0", busy, 1);
      checkOutput("sw_ready_e0", ready, 0);
      checkOutput("sw_strobe_e0", strobe, 0);
      tick();
      checkOutput("sw_strobe_e1", strobe, 0);
      tick();
      checkOutput("sw_strobe_e2", strobe, 1);
      tick();
      checkOutput("sw_strobe_e3", strobe, 0);
      checkOutput("sw_busy_e3", busy, 1);
      tick();
      checkOutput("sw_busy_e4", busy, 0);
      checkOutput("sw_ready_e4", ready, 1);
      checkOutput("sw_data_e4", data_out, 8'hA5);

      // Input changes while busy are ignored; exactly one strobe
      applyStimulus(1'b1, 8'hA5);
      tick();
      applyStimulus(1'b1, 8'hFF);
      strobe_count = 0;
      for (int i = 1; i <= 4; i++) begin
         tick();
         if (strobe) strobe_count++;
         if (i == 4) applyStimulus(1'b0, 8'hFF);
      end
      for (int i = 0; i < 3; i++) begin
         tick();
         if (strobe) strobe_count++;
      end
      checkOutput("ign_data", data_out, 8'hA5);
      checkOutput("ign_strobes", strobe_count, 1);
      checkOutput("ign_busy", busy, 0);

      // Back-to-back with valid held: 0x11 at edge 0, 0x22 at edge 5
      applyStimulus(1'b1, 8'h11);
      tick();
      checkOutput("b2b_data_e0", data_out, 8'h11);
      applyStimulus(1'b1, 8'h22);
      tick();
      checkOutput("b2b_strobe_e1", strobe, 0);
      tick();
      checkOutput("b2b_strobe_e2", strobe, 1);
      tick();
      checkOutput("b2b_data_e3", data_out, 8'h11);
      tick();
      checkOutput("b2b_data_e4", data_out, 8'h11);
      checkOutput("b2b_ready_e4", ready, 1);
      tick();
      applyStimulus(1'b0, 8'h00);
      checkOutput("b2b_data_e5", data_out, 8'h22);
      checkOutput("b2b_busy_e5", busy, 1);
      tick();
      checkOutput("b2b_strobe_e6", strobe, 0);
      tick();
      checkOutput("b2b_strobe_e7", strobe, 1);
      tick();
      checkOutput("b2b_strobe_e8", strobe, 0);
      tick();
      checkOutput("b2b_idle_e9", busy, 0);

      // Reset one edge after acceptance drops the word without a strobe
      applyStimulus(1'b1, 8'h3C);
      tick();
      applyStimulus(1'b0, 8'h00);
      checkOutput("mid_data_e0", data_out, 8'h3C);
      reset = 1'b1;
      tick();
      checkOutput("mid_data_e1", data_out, 8'h00);
      checkOutput("mid_busy_e1", busy, 0);
      checkOutput("mid_strobe_e1", strobe, 0);
      checkOutput("mid_ready_rst", ready, 0);
      reset = 1'b0;
      #1;
      checkOutput("mid_ready_rel", ready, 1);
      strobe_count = 0;
      for (int i = 0; i < 4; i++) begin
         tick();
         if (strobe) strobe_count++;
      end
      checkOutput("mid_no_strobe", strobe_count, 0);
      checkOutput("mid_idle", busy, 0);

      // Short timing instance: 0x07 at edge 0, strobe after edge 1, next at edge 3
      valid2   = 1'b1;
      data_in2 = 8'h07;
      tick();
      valid2   = 1'b0;
      checkOutput("s1_data_e0", data_out2, 8'h07);
      checkOutput("s1_busy_e0", busy2, 1);
      checkOutput("s1_strobe_e0", strobe2, 0);
`ifdef CC_DATASENDER_PARITY_EN
      checkOutput("s1_parity_07", parity2, 1);
`endif
      tick();
      checkOutput("s1_strobe_e1", strobe2, 1);
      tick();
      checkOutput("s1_strobe_e2", strobe2, 0);
      checkOutput("s1_ready_e2", ready2, 1);
      checkOutput("s1_busy_e2", busy2, 0);
      valid2   = 1'b1;
      data_in2 = 8'h03;
      tick();
      valid2   = 1'b0;
      checkOutput("s1_data_e3", data_out2, 8'h03);
      checkOutput("s1_busy_e3", busy2, 1);
`ifdef CC_DATASENDER_PARITY_EN
      checkOutput("s1_parity_03", parity2, 0);
`endif
      tick();
      checkOutput("s1_strobe_e4", strobe2, 1);
      tick();
      checkOutput("s1_strobe_e5", strobe2, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/cc_datasender.md
# cc_datasender

Transmit-side companion of the data-delay stage: accepts words from upstream logic over a valid/ready handshake and drives them onto the data bus. It holds each word stable for a programmable setup time, fires a single-cycle send strobe, then holds the word for a programmable hold time. It sits between game-logic producers and the delay/receive path, and generates the `SendDataSignal` that the delay stage consumes.

## Interface
- `DATAWIDTH_BUS`, 8: data word width.
- `SETUP_CYCLES`, 2: cycles the data is stable before the strobe; legal range ≥1.
- `HOLD_CYCLES`, 1: cycles the data is stable after the strobe; legal range ≥0.

- `CC_DATASENDER_CLOCK_50`  in  1  system clock; all state updates on its rising edge.
- `CC_DATASENDER_RESET_InHigh`  in  1  synchronous, active-high reset.
- `CC_DATASENDER_Data_inBus`  in  DATAWIDTH_BUS  word offered by the upstream producer.
- `CC_DATASENDER_DataValid_In`  in  1  upstream word valid.
- `CC_DATASENDER_DataReady_Out`  out  1  block can accept a word this cycle.
- `CC_DATASENDER_Data_outBus`  out  DATAWIDTH_BUS  registered word driven toward the delay stage.
- `CC_DATASENDER_SendDataSignal_Out`  out  1  registered one-cycle send strobe.
- `CC_DATASENDER_Busy_Out`  out  1  high while a word is in flight (any state except IDLE).

## Operation
- FSM states: IDLE, SETUP, STROBE, HOLD. Reset state is IDLE.
- Accept: a word is accepted at an edge where `DataValid_In & DataReady_Out` is 1.
  - On acceptance, `Data_inBus` is registered into `Data_outBus`.
  - The down-counter is loaded with `SETUP_CYCLES-1`.
  - The FSM moves IDLE→SETUP.
- SETUP: counter decrements each cycle. When the counter is 0, the FSM goes to STROBE.
- STROBE: lasts exactly one cycle.
  - If `HOLD_CYCLES`=0, the FSM goes to IDLE.
  - Otherwise the counter is loaded with `HOLD_CYCLES-1` and the FSM goes to HOLD.
- HOLD: counter decrements each cycle. When the counter is 0, the FSM goes to IDLE.
- `DataReady_Out` = (state==IDLE) & ~RESET_InHigh. This is a Moore decode; there is no skid buffer, so no word is accepted outside IDLE.
- `SendDataSignal_Out` is registered high only while in STROBE.
- `Data_outBus` changes only on acceptance. It retains the last word indefinitely in IDLE.
- The counter is $clog2(max(SETUP_CYCLES,HOLD_CYCLES)+1) bits wide and never wraps: loads and decrements are bounded by the states above.
- `DataValid_In` is ignored outside IDLE. `Data_inBus` changes during SETUP/STROBE/HOLD have no effect on `Data_outBus`.
- Reset mid-operation: at the reset edge, the FSM goes to IDLE and the counter goes to 0. A word in flight is dropped, with no strobe issued.

## Timing
- Reset values:
  - `Data_outBus`=0, `SendDataSignal_Out`=0, `Busy_Out`=0.
  - `DataReady_Out`=0 while reset is asserted; 1 in the first cycle after reset is released.
- Acceptance at edge E0:
  - `Data_outBus` is valid and `Busy_Out`=1 from E0.
  - `SendDataSignal_Out`=1 for exactly the cycle following edge E0+SETUP_CYCLES.
  - `Busy_Out` falls and `DataReady_Out` rises after edge E0+SETUP_CYCLES+HOLD_CYCLES+1.
- Earliest next acceptance: edge E0+SETUP_CYCLES+HOLD_CYCLES+2. This gives a throughput of one word per SETUP_CYCLES+HOLD_CYCLES+2 cycles (5 with defaults).
- The strobe is never asserted on two consecutive cycles.

## Configuration
- Macro: `CC_DATASENDER_PARITY_EN`.
- Defined: adds output `CC_DATASENDER_Parity_Out` (1 bit).
  - Value is the even parity (XOR reduction) of `Data_inBus`, registered on the same acceptance edge as `Data_outBus`.
  - Resets to 0 and is held with the data.
- Undefined: the port and its register do not exist. All other behaviour is identical.

## Test plan
- Reset: assert `RESET_InHigh` for 3 cycles with `DataValid_In`=1 → `DataReady_Out`=0, `Data_outBus`=0x00, `SendDataSignal_Out`=0, `Busy_Out`=0 throughout. `DataReady_Out`=1 in the cycle after release.
- Single word, defaults: 0xA5 accepted at edge 0 →
  - `Data_outBus`=0xA5 from edge 0.
  - strobe high only in the cycle after edge 2.
  - `Busy_Out` low and `DataReady_Out` high after edge 4.
- Back-to-back, defaults: `DataValid_In` held high with 0x11 then 0x22 → 0x11 accepted at edge 0 and 0x22 at edge 5. Strobes follow edges 2 and 7. `Data_outBus`=0x11 until edge 5.
- Input ignored when busy: change `Data_inBus` to 0xFF during SETUP and HOLD → `Data_outBus` stays 0xA5; no extra acceptance; exactly one strobe.
- Reset mid-flight: reset at edge 1 after acceptance at edge 0 → no strobe; FSM in IDLE; `Data_outBus`=0x00; `DataReady_Out`=1 after release.
- Parity (macro defined), SETUP_CYCLES=1, HOLD_CYCLES=0: send 0x07 →
  - `Parity_Out`=1, strobe in the cycle after edge 1, next acceptance possible at edge 3.
  - Then send 0x03 → `Parity_Out`=0.
